// File: rtl/seg7_pkg.sv
// seg7_pkg: shared types and constants for the seg7_countdown timer.
//   state_t      - countdown controller states
//   SEG_0..SEG_9 - active-high segment patterns {a,b,c,d,e,f,g}
//   SEG_BLANK    - all segments off
//   bcd_to_seg7  - one BCD digit to its segment pattern (non-BCD codes blank)
package seg7_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        PAUSE = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam logic [6:0] SEG_0     = 7'b1111110;
    localparam logic [6:0] SEG_1     = 7'b0110000;
    localparam logic [6:0] SEG_2     = 7'b1101101;
    localparam logic [6:0] SEG_3     = 7'b1111001;
    localparam logic [6:0] SEG_4     = 7'b0110011;
    localparam logic [6:0] SEG_5     = 7'b1011011;
    localparam logic [6:0] SEG_6     = 7'b1011111;
    localparam logic [6:0] SEG_7     = 7'b1110000;
    localparam logic [6:0] SEG_8     = 7'b1111111;
    localparam logic [6:0] SEG_9     = 7'b1111011;
    localparam logic [6:0] SEG_BLANK = 7'b0000000;

    function automatic logic [6:0] bcd_to_seg7(input logic [3:0] bcd);
        logic [6:0] seg;
        case (bcd)
            4'd0:    seg = SEG_0;
            4'd1:    seg = SEG_1;
            4'd2:    seg = SEG_2;
            4'd3:    seg = SEG_3;
            4'd4:    seg = SEG_4;
            4'd5:    seg = SEG_5;
            4'd6:    seg = SEG_6;
            4'd7:    seg = SEG_7;
            4'd8:    seg = SEG_8;
            4'd9:    seg = SEG_9;
            default: seg = SEG_BLANK;
        endcase
        return seg;
    endfunction

endpackage

// File: rtl/seg7_countdown_decoder.sv
// seg7_decoder: combinational decode of one BCD digit to a 7-segment pattern.
//   bcd - 4-bit BCD digit
//   seg - active-high pattern {a,b,c,d,e,f,g}
module seg7_decoder
    import seg7_pkg::*;
(
    input  logic [3:0] bcd,
    output logic [6:0] seg
);

    assign seg = bcd_to_seg7(bcd);

endmodule

// File: rtl/seg7_countdown.sv
// seg7_countdown: multi-digit BCD countdown timer with 7-segment outputs.
//   clk, rst      - clock; asynchronous active-high reset
//   load          - capture load_value (digits >9 clamped to 9); top priority
//   load_value    - BCD start value, digit 0 in [3:0]
//   start         - begin (from IDLE) or resume (from PAUSE) counting
//   pause         - freeze count and prescaler while running
//   count_bcd     - registered BCD count
//   seg7          - per-digit segment patterns, digit 0 in [6:0]
//   busy          - high in RUN or PAUSE
//   done          - one-cycle pulse when the count reaches zero
// Optional macro SEG7_TIMER_BLANK_EN enables leading-zero blanking of seg7.
module seg7_countdown
    import seg7_pkg::*;
#(
    parameter int TICK_DIV = 50_000_000,
    parameter int DIGITS   = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  load,
    input  logic [4*DIGITS-1:0]   load_value,
    input  logic                  start,
    input  logic                  pause,
    output logic [4*DIGITS-1:0]   count_bcd,
    output logic [7*DIGITS-1:0]   seg7,
    output logic                  busy,
    output logic                  done
);

    localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);

    state_t              state_q, state_d;
    logic [4*DIGITS-1:0] count_q, count_d;
    logic [PW-1:0]       presc_q, presc_d;

    logic [4*DIGITS-1:0] count_clamped;
    logic [4*DIGITS-1:0] count_dec;
    logic [DIGITS-1:0]   borrow;
    logic                tick;

    assign borrow[0] = 1'b1;

    // Per-digit clamp of the load value and BCD borrow chain for one step down.
    generate
        for (genvar gi = 0; gi < DIGITS; gi++) begin : g_digit
            logic [3:0] ld_digit;
            logic [3:0] cur_digit;
            assign ld_digit  = load_value[4*gi +: 4];
            assign cur_digit = count_q[4*gi +: 4];
            assign count_clamped[4*gi +: 4] = (ld_digit > 4'd9) ? 4'd9 : ld_digit;
            assign count_dec[4*gi +: 4] = !borrow[gi]         ? cur_digit :
                                          (cur_digit == 4'd0) ? 4'd9      :
                                                                cur_digit - 4'd1;
            if (gi < DIGITS - 1) begin : g_borrow
                assign borrow[gi+1] = borrow[gi] && (cur_digit == 4'd0);
            end
        end
    endgenerate

    assign tick = (presc_q == PRESC_LAST);

    always_comb begin
        state_d = state_q;
        count_d = count_q;
        presc_d = presc_q;
        if (load) begin
            count_d = count_clamped;
            presc_d = '0;
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start) begin
                        // Starting at zero completes at once without a step.
                        if (count_q == '0) begin
                            state_d = DONE;
                        end else begin
                            state_d = RUN;
                            presc_d = '0;
                        end
                    end
                end
                PAUSE: begin
                    if (start) begin
                        state_d = RUN;  // prescaler phase carried over
                    end
                end
                RUN: begin
                    if (pause) begin
                        state_d = PAUSE;
                    end else if (tick) begin
                        presc_d = '0;
                        count_d = count_dec;
                        if (count_dec == '0) begin
                            state_d = DONE;
                        end
                    end else begin
                        presc_d = presc_q + 1'b1;
                    end
                end
                DONE: begin
                    state_d = IDLE;
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            count_q <= '0;
            presc_q <= '0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            presc_q <= presc_d;
        end
    end

    assign count_bcd = count_q;
    assign busy      = (state_q == RUN) || (state_q == PAUSE);
    assign done      = (state_q == DONE);

    // blank[i] forces digit i dark; digit 0 is never blanked.
    logic [DIGITS-1:0] blank;
`ifdef SEG7_TIMER_BLANK_EN
    logic nz_above;
    always_comb begin
        blank    = '0;
        nz_above = 1'b0;
        for (int i = DIGITS - 1; i >= 1; i--) begin
            blank[i] = !nz_above && (count_q[4*i +: 4] == 4'd0);
            nz_above = nz_above || (count_q[4*i +: 4] != 4'd0);
        end
    end
`else
    assign blank = '0;
`endif

    generate
        for (genvar gi = 0; gi < DIGITS; gi++) begin : g_seg
            logic [6:0] raw_seg;
            seg7_decoder u_dec (
                .bcd (count_q[4*gi +: 4]),
                .seg (raw_seg)
            );
            assign seg7[7*gi +: 7] = blank[gi] ? SEG_BLANK : raw_seg;
        end
    endgenerate

endmodule

// File: tb/tb_seg7_countdown.sv
module tb_seg7_countdown;

    localparam int TICK = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        load = 1'b0;
    logic [7:0]  load_value = 8'h00;
    logic        start = 1'b0;
    logic        pause = 1'b0;
    logic [7:0]  count_bcd;
    logic [13:0] seg7;
    logic        busy;
    logic        done;

    int n_checks = 0;
    int n_fail   = 0;

    seg7_countdown #(.TICK_DIV(TICK), .DIGITS(2)) dut (
        .clk        (clk),
        .rst        (rst),
        .load       (load),
        .load_value (load_value),
        .start      (start),
        .pause      (pause),
        .count_bcd  (count_bcd),
        .seg7       (seg7),
        .busy       (busy),
        .done       (done)
    );

    always #5 clk = ~clk;

    // Reference model: decimal count value, phase counter, mode code.
    localparam int M_IDLE = 0, M_RUN = 1, M_PAUSE = 2, M_DONE = 3;
    int m_val   = 0;
    int m_phase = 0;
    int m_mode  = M_IDLE;

    function automatic logic [6:0] seg_of(input int d);
        case (d)
            0: return 7'b1111110;
            1: return 7'b0110000;
            2: return 7'b1101101;
            3: return 7'b1111001;
            4: return 7'b0110011;
            5: return 7'b1011011;
            6: return 7'b1011111;
            7: return 7'b1110000;
            8: return 7'b1111111;
            9: return 7'b1111011;
            default: return 7'b0000000;
        endcase
    endfunction

    function automatic logic [13:0] exp_seg(input int v);
        logic [6:0] hi;
        hi = seg_of(v / 10);
`ifdef SEG7_TIMER_BLANK_EN
        if (v / 10 == 0) hi = 7'b0000000;
`endif
        return {hi, seg_of(v % 10)};
    endfunction

    function automatic logic [7:0] exp_bcd(input int v);
        return {4'(v / 10), 4'(v % 10)};
    endfunction

    function automatic int clamp_val(input logic [7:0] lv);
        int hi, lo;
        hi = (lv[7:4] > 4'd9) ? 9 : int'(lv[7:4]);
        lo = (lv[3:0] > 4'd9) ? 9 : int'(lv[3:0]);
        return hi * 10 + lo;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_edge(input logic ld, input logic [7:0] lv, input logic st, input logic ps);
        if (ld) begin
            m_val = clamp_val(lv); m_phase = 0; m_mode = M_IDLE;
        end else begin
            case (m_mode)
                M_IDLE:  if (st) begin
                             if (m_val == 0) m_mode = M_DONE;
                             else begin m_mode = M_RUN; m_phase = 0; end
                         end
                M_PAUSE: if (st) m_mode = M_RUN;
                M_RUN:   if (ps) m_mode = M_PAUSE;
                         else if (m_phase == TICK - 1) begin
                             m_phase = 0;
                             m_val   = m_val - 1;
                             if (m_val == 0) m_mode = M_DONE;
                         end else m_phase++;
                default: m_mode = M_IDLE;
            endcase
        end
    endtask

    // Drive one cycle of inputs, clock it, then compare everything with the model.
    task automatic step(input logic ld, input logic [7:0] lv, input logic st, input logic ps);
        load = ld; load_value = lv; start = st; pause = ps;
        @(posedge clk);
        model_edge(ld, lv, st, ps);
        #1;
        chk("count", 32'(count_bcd), 32'(exp_bcd(m_val)));
        chk("seg7", 32'(seg7), 32'(exp_seg(m_val)));
        chk("busy", 32'(busy), 32'(m_mode == M_RUN || m_mode == M_PAUSE));
        chk("done", 32'(done), 32'(m_mode == M_DONE));
        $display("cyc ld=%0b lv=%h st=%0b ps=%0b -> count=%h busy=%0b done=%0b",
                 ld, lv, st, ps, count_bcd, busy, done);
    endtask

    typedef struct {
        logic [7:0] lv;
        logic [7:0] exp_count;
    } ld_vec_t;

    initial begin
        ld_vec_t vecs[7];
        int done_cycle, done_cnt;

        vecs[0] = '{8'h12, 8'h12};
        vecs[1] = '{8'h5C, 8'h59};
        vecs[2] = '{8'hC5, 8'h95};
        vecs[3] = '{8'hFF, 8'h99};
        vecs[4] = '{8'h07, 8'h07};
        vecs[5] = '{8'h90, 8'h90};
        vecs[6] = '{8'h00, 8'h00};

        // Reset (asynchronous, before any clock edge)
        #2 rst = 1'b1;
        #1;
        chk("rst_count", 32'(count_bcd), 32'h00);
        chk("rst_seg7", 32'(seg7), 32'(14'b1111110_1111110));
        chk("rst_busy", 32'(busy), 0);
        chk("rst_done", 32'(done), 0);
        @(posedge clk); @(posedge clk); #1;
        rst = 1'b0;

        // Load table with clamping
        foreach (vecs[i]) begin
            step(1'b1, vecs[i].lv, 1'b0, 1'b0);
            chk("load_tbl", 32'(count_bcd), 32'(vecs[i].exp_count));
        end

        // Basic countdown from 12
        step(1'b1, 8'h12, 1'b0, 1'b0);
        step(1'b0, 8'h00, 1'b1, 1'b0);   // cycle 1 after start
        done_cycle = -1; done_cnt = 0;
        for (int c = 2; c <= 52; c++) begin
            step(1'b0, 8'h00, 1'b0, 1'b0);
            if (c == 5)  chk("cd_11", 32'(count_bcd), 32'h11);
            if (c == 9)  chk("cd_10", 32'(count_bcd), 32'h10);
            if (c == 13) chk("cd_09_borrow", 32'(count_bcd), 32'h09);
            if (done) begin done_cnt++; if (done_cycle < 0) done_cycle = c; end
        end
        chk("done_cycle", 32'(done_cycle), 49);
        chk("done_pulses", 32'(done_cnt), 1);
        chk("cd_idle_busy", 32'(busy), 0);

        // Pause / resume preserves prescaler phase
        step(1'b1, 8'h12, 1'b0, 1'b0);
        step(1'b0, 8'h00, 1'b1, 1'b0);   // cycle 1
        for (int c = 2; c <= 7; c++) step(1'b0, 8'h00, 1'b0, 1'b0);
        step(1'b0, 8'h00, 1'b0, 1'b1);   // pause sampled with phase 2
        for (int c = 0; c < 10; c++) begin
            step(1'b0, 8'h00, 1'b0, 1'b0);
            chk("pause_hold", 32'(count_bcd), 32'h11);
        end
        step(1'b0, 8'h00, 1'b1, 1'b0);
        chk("resume_1", 32'(count_bcd), 32'h11);
        step(1'b0, 8'h00, 1'b0, 1'b0);
        chk("resume_2", 32'(count_bcd), 32'h11);
        step(1'b0, 8'h00, 1'b0, 1'b0);
        chk("resume_tick", 32'(count_bcd), 32'h10);

        // Start at zero: immediate done, no wrap
        step(1'b1, 8'h00, 1'b0, 1'b0);
        step(1'b0, 8'h00, 1'b1, 1'b0);
        chk("zero_done", 32'(done), 1);
        chk("zero_count", 32'(count_bcd), 32'h00);
        step(1'b0, 8'h00, 1'b0, 1'b0);
        chk("zero_nowrap", 32'(count_bcd), 32'h00);
        chk("zero_idle", 32'(done), 0);

        // load + start together while running
        step(1'b1, 8'h12, 1'b0, 1'b0);
        step(1'b0, 8'h00, 1'b1, 1'b0);
        for (int c = 0; c < 5; c++) step(1'b0, 8'h00, 1'b0, 1'b0);
        step(1'b1, 8'h34, 1'b1, 1'b0);
        chk("prio_count", 32'(count_bcd), 32'h34);
        chk("prio_busy", 32'(busy), 0);
        for (int c = 0; c < 12; c++) step(1'b0, 8'h00, 1'b0, 1'b0);
        chk("prio_held", 32'(count_bcd), 32'h34);

        // Segment display of 07
        step(1'b1, 8'h07, 1'b0, 1'b0);
        chk("seg_d0_7", 32'(seg7[6:0]), 32'(7'b1110000));
`ifdef SEG7_TIMER_BLANK_EN
        chk("seg_d1_blank", 32'(seg7[13:7]), 32'(7'b0000000));
`else
        chk("seg_d1_zero", 32'(seg7[13:7]), 32'(7'b1111110));
`endif

        // Async reset mid-run
        step(1'b0, 8'h00, 1'b1, 1'b0);
        for (int c = 0; c < 3; c++) step(1'b0, 8'h00, 1'b0, 1'b0);
        #2 rst = 1'b1;
        #1;
        chk("arst_count", 32'(count_bcd), 32'h00);
        chk("arst_seg7", 32'(seg7), 32'(14'b1111110_1111110));
        chk("arst_busy", 32'(busy), 0);
        chk("arst_done", 32'(done), 0);
        m_val = 0; m_phase = 0; m_mode = M_IDLE;
        load = 1'b0; start = 1'b0; pause = 1'b0;
        @(posedge clk); #1;
        chk("arst_hold_done", 32'(done), 0);
        rst = 1'b0;

        // Randomized traffic against the model
        for (int i = 0; i < 600; i++) begin
            logic ld, st, ps;
            logic [7:0] lv;
            ld = ($urandom_range(0, 19) == 0);
            lv = 8'($urandom);
            st = ($urandom_range(0, 3) == 0);
            ps = ($urandom_range(0, 7) == 0);
            step(ld, lv, st, ps);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
